// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: word-level types shared across the CPU datapath and memory blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/dcache_pkg.sv
// dcache_pkg: cache state encoding, frame layout and fixed addresses for dcache.
package dcache_pkg;
  import cpu_types_pkg::*;
  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FLUSH_WB0, FLUSH_WB1, CNT_WR, HALTED
  } dcache_state_t;
  // tag field is sized for the smallest legal index so any SETS fits
  typedef struct packed {
    logic valid;
    logic dirty;
    logic [28:0] tag;
    word_t [1:0] data;
  } dcache_frame_t;
  localparam word_t HITCNT_ADDR = 32'h3100;
  function automatic word_t blk_addr(input logic [28:0] tag, input int iw, input word_t idx, input logic n);
    return (word_t'(tag) << (3 + iw)) | (idx << 3) | {29'b0, n, 2'b00};
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: datapath request/response and word-serial memory port of the data cache.
interface dcache_if;
  import cpu_types_pkg::*;
  logic dmemREN, dmemWEN, datomic, halt;
  word_t dmemaddr, dmemstore;
  logic dhit, flushed;
  word_t dmemload;
  logic dREN, dWEN, dwait;
  word_t daddr, dstore, dload;
  modport slave (
    input dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
  modport master (
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, dwait, dload,
    input dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_frames.sv
// dcache_frames: direct-mapped frame store; sync write, combinational read of one index.
module dcache_frames import cpu_types_pkg::*; import dcache_pkg::*; #(
  parameter int SETS = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic [$clog2(SETS)-1:0] idx,
  input  logic we,
  input  dcache_frame_t wframe,
  output dcache_frame_t frame
);
  logic [SETS-1:0] valid, dirty;
  logic [28:0] tags [SETS];
  word_t [1:0] data [SETS];
  // only the state bits need reset; tag/data are meaningless while invalid
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[idx] <= wframe.valid;
      dirty[idx] <= wframe.dirty;
    end
  always_ff @(posedge CLK)
    if (we) begin
      tags[idx] <= wframe.tag;
      data[idx] <= wframe.data;
    end
  assign frame = '{valid: valid[idx], dirty: dirty[idx], tag: tags[idx], data: data[idx]};
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back data cache, 2-word blocks, LL/SC link, flush on halt.
// Optional DCACHE_HITCNT_EN adds hit/miss counters written to HITCNT_ADDR after the flush.
module dcache import cpu_types_pkg::*; import dcache_pkg::*; #(
  parameter int SETS = 8
) (
  input logic CLK,
  input logic nRST,
  dcache_if.slave bus
);
  localparam int IW = $clog2(SETS);
`ifdef DCACHE_HITCNT_EN
  localparam dcache_state_t FLUSH_END = CNT_WR;
  word_t hits, misses;
  logic filled;
`else
  localparam dcache_state_t FLUSH_END = HALTED;
`endif
  dcache_state_t state, next_state;
  dcache_frame_t frame, wframe;
  logic we, fidx_inc, done, acc;
  logic [IW-1:0] idx, fidx, req_idx;
  logic [28:0] req_tag;
  logic blkoff, req, hit, sc, sc_fail, last, unused_bits;
  logic [29:0] link_addr;
  logic link_valid;
  word_t fbuf;
  assign req_tag = 29'(bus.dmemaddr[31:3+IW]);
  assign req_idx = bus.dmemaddr[2+IW:3];
  assign blkoff = bus.dmemaddr[2];
  assign unused_bits = ^bus.dmemaddr[1:0];
  assign req = bus.dmemREN | bus.dmemWEN;
  assign hit = frame.valid && frame.tag == req_tag;
  assign sc = bus.dmemWEN & bus.datomic;
  assign sc_fail = sc & ~(link_valid && link_addr == bus.dmemaddr[31:2]);
  assign last = fidx == IW'(SETS - 1);
  assign acc = done & ~sc_fail;
  assign bus.dhit = done & nRST;
  dcache_frames #(.SETS(SETS)) u_frames (
    .CLK(CLK), .nRST(nRST), .idx(idx), .we(we), .wframe(wframe), .frame(frame)
  );
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      fidx <= '0;
      fbuf <= '0;
      link_valid <= 1'b0;
      link_addr <= '0;
    end else begin
      state <= next_state;
      if (fidx_inc) fidx <= fidx + 1'b1;
      if (state == FETCH0 && !bus.dwait) fbuf <= bus.dload;
      if (acc && bus.dmemREN && bus.datomic) begin
        link_valid <= 1'b1;
        link_addr <= bus.dmemaddr[31:2];
      end else if (acc && bus.dmemWEN && link_addr == bus.dmemaddr[31:2]) link_valid <= 1'b0;
    end
`ifdef DCACHE_HITCNT_EN
  // a request that needed a fill was already counted as a miss
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      hits <= '0;
      misses <= '0;
      filled <= 1'b0;
    end else begin
      if (state == IDLE && (next_state == WB0 || next_state == FETCH0)) misses <= misses + 1'b1;
      if (acc && !filled) hits <= hits + 1'b1;
      if (state == FETCH1 && !bus.dwait) filled <= 1'b1;
      else if (acc) filled <= 1'b0;
    end
`endif
  always_comb begin
    next_state = state;
    idx = req_idx;
    we = 1'b0;
    wframe = frame;
    fidx_inc = 1'b0;
    done = 1'b0;
    bus.dmemload = '0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    bus.daddr = '0;
    bus.dstore = '0;
    bus.flushed = 1'b0;
    case (state)
      IDLE:
        if (bus.halt) next_state = FLUSH_CHK;
        else if (req && (sc_fail || hit)) begin
          done = 1'b1;
          bus.dmemload = sc ? {31'b0, ~sc_fail} : frame.data[blkoff];
          if (bus.dmemWEN && !sc_fail) begin
            we = 1'b1;
            wframe.dirty = 1'b1;
            wframe.data[blkoff] = bus.dmemstore;
          end
        end else if (req) next_state = (frame.valid && frame.dirty) ? WB0 : FETCH0;
      WB0, WB1: begin
        bus.dWEN = 1'b1;
        bus.daddr = blk_addr(frame.tag, IW, word_t'(idx), state == WB1);
        bus.dstore = frame.data[state == WB1];
        if (!bus.dwait) next_state = (state == WB0) ? WB1 : FETCH0;
      end
      FETCH0, FETCH1: begin
        bus.dREN = 1'b1;
        bus.daddr = blk_addr(req_tag, IW, word_t'(idx), state == FETCH1);
        if (!bus.dwait) next_state = (state == FETCH0) ? FETCH1 : IDLE;
        if (!bus.dwait && state == FETCH1) begin
          we = 1'b1;
          wframe = '{valid: 1'b1, dirty: 1'b0, tag: req_tag, data: {bus.dload, fbuf}};
        end
      end
      FLUSH_CHK: begin
        idx = fidx;
        if (frame.valid && frame.dirty) next_state = FLUSH_WB0;
        else begin
          fidx_inc = !last;
          next_state = last ? FLUSH_END : FLUSH_CHK;
        end
      end
      FLUSH_WB0, FLUSH_WB1: begin
        idx = fidx;
        bus.dWEN = 1'b1;
        bus.daddr = blk_addr(frame.tag, IW, word_t'(fidx), state == FLUSH_WB1);
        bus.dstore = frame.data[state == FLUSH_WB1];
        if (!bus.dwait && state == FLUSH_WB0) next_state = FLUSH_WB1;
        else if (!bus.dwait) begin
          we = 1'b1;
          wframe.dirty = 1'b0;
          fidx_inc = !last;
          next_state = last ? FLUSH_END : FLUSH_CHK;
        end
      end
`ifdef DCACHE_HITCNT_EN
      CNT_WR: begin
        bus.dWEN = 1'b1;
        bus.daddr = HITCNT_ADDR;
        bus.dstore = hits - misses;
        if (!bus.dwait) next_state = HALTED;
      end
`endif
      HALTED: bus.flushed = 1'b1;
      default: next_state = state;
    endcase
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: scoreboard bench for dcache with a latency-modelled word-serial memory.
module tb_dcache;
  import cpu_types_pkg::*;
  import dcache_pkg::*;
  typedef struct {logic w; word_t a; word_t d;} mtx_t;
  logic CLK = 1'b0, nRST = 1'b0;
  int vectors = 0, miscompares = 0, lat = 2, cnt = 0, nhit = 0, nmiss = 0;
  word_t mem [word_t];
  mtx_t exp_m [$];
  word_t exp_q [$];
  dcache_if bus ();
  dcache #(.SETS(8)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic word_t pat(input word_t a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic rd_m(input word_t a);
    exp_m.push_back('{1'b0, a, 32'h0});
  endtask

  task automatic wr_m(input word_t a, input word_t d);
    exp_m.push_back('{1'b1, a, d});
  endtask

  // memory: dwait high for lat cycles of each transfer, then one completing cycle
  always @(negedge CLK)
    if (bus.dREN || bus.dWEN) begin
      if (cnt < lat) begin
        bus.dwait = 1'b1;
        cnt++;
      end else begin
        bus.dwait = 1'b0;
        bus.dload = mem.exists(bus.daddr) ? mem[bus.daddr] : pat(bus.daddr);
      end
    end else begin
      bus.dwait = 1'b1;
      cnt = 0;
    end

  always @(posedge CLK)
    if (nRST && (bus.dREN || bus.dWEN) && !bus.dwait) begin
      mtx_t e;
      check("mem_expected", exp_m.size() > 0, 1);
      if (exp_m.size() > 0) begin
        e = exp_m.pop_front();
        check("mem_dir", bus.dWEN, e.w);
        check("mem_addr", bus.daddr, e.a);
        if (e.w) check("mem_data", bus.dstore, e.d);
      end
      if (bus.dWEN) mem[bus.daddr] = bus.dstore;
      cnt = 0;
    end

  task automatic access(input logic r, input logic w, input logic at, input word_t a, input word_t d,
                        input logic chk_d, input word_t exp, input logic miss, input logic scf);
    int cyc;
    word_t e;
    @(negedge CLK);
    bus.dmemREN = r;
    bus.dmemWEN = w;
    bus.datomic = at;
    bus.dmemaddr = a;
    bus.dmemstore = d;
    if (chk_d) exp_q.push_back(exp);
    cyc = 0;
    #1;
    while (!bus.dhit && cyc < 200) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    check("dhit", bus.dhit, 1);
    check("miss_latency", cyc != 0, miss);
    if (chk_d) begin
      e = exp_q.pop_front();
      check("dmemload", bus.dmemload, e);
    end
    if (!scf) begin
      if (miss) nmiss++;
      else nhit++;
    end
    @(posedge CLK);
    #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.datomic = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.datomic = 1'b0;
    bus.dmemaddr = '0;
    bus.dmemstore = '0;
    bus.halt = 1'b0;
    bus.dwait = 1'b1;
    bus.dload = '0;
    mem[32'h40] = 32'hAAAA_0001;
    mem[32'h44] = 32'hAAAA_0002;
    #12;
    check("rst_dhit", bus.dhit, 0);
    check("rst_dren", bus.dREN, 0);
    check("rst_dwen", bus.dWEN, 0);
    check("rst_flushed", bus.flushed, 0);
    check("rst_daddr", bus.daddr, 0);
    nRST = 1'b1;
    rd_m(32'h40); rd_m(32'h44);
    access(1, 0, 0, 32'h40, 0, 1, 32'hAAAA_0001, 1, 0);
    access(1, 0, 0, 32'h44, 0, 1, 32'hAAAA_0002, 0, 0);
    access(0, 1, 0, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 0);
    wr_m(32'h40, 32'hDEAD_BEEF); wr_m(32'h44, 32'hAAAA_0002); rd_m(32'h140); rd_m(32'h144);
    access(1, 0, 0, 32'h140, 0, 1, pat(32'h140), 1, 0);
    rd_m(32'h80); rd_m(32'h84);
    access(1, 0, 1, 32'h80, 0, 1, pat(32'h80), 1, 0);
    access(0, 1, 1, 32'h80, 5, 1, 1, 0, 0);
    access(1, 0, 0, 32'h80, 0, 1, 5, 0, 0);
    access(0, 1, 1, 32'h80, 7, 1, 0, 0, 1);
    access(1, 0, 0, 32'h80, 0, 1, 5, 0, 0);
    access(1, 0, 1, 32'h80, 0, 1, 5, 0, 0);
    access(0, 1, 0, 32'h80, 9, 0, 0, 0, 0);
    access(0, 1, 1, 32'h80, 6, 1, 0, 0, 1);
    access(1, 0, 0, 32'h80, 0, 1, 9, 0, 0);
    access(1, 0, 1, 32'h80, 0, 1, 9, 0, 0);
    access(0, 1, 1, 32'h84, 6, 1, 0, 0, 1);
    access(1, 0, 0, 32'h84, 0, 1, pat(32'h84), 0, 0);
    wr_m(32'h80, 9); wr_m(32'h84, pat(32'h84)); rd_m(32'h100); rd_m(32'h104);
    access(1, 0, 0, 32'h100, 0, 1, pat(32'h100), 1, 0);
    rd_m(32'h48); rd_m(32'h4C);
    access(0, 1, 0, 32'h48, 32'h11, 0, 0, 1, 0);
    rd_m(32'h68); rd_m(32'h6C);
    access(0, 1, 0, 32'h6C, 32'h22, 0, 0, 1, 0);
    check("pre_halt_drain", exp_m.size(), 0);
    wr_m(32'h48, 32'h11); wr_m(32'h4C, pat(32'h4C)); wr_m(32'h68, pat(32'h68)); wr_m(32'h6C, 32'h22);
`ifdef DCACHE_HITCNT_EN
    wr_m(HITCNT_ADDR, word_t'(nhit - nmiss));
`endif
    @(negedge CLK);
    bus.halt = 1'b1;
    cyc = 0;
    #1;
    while (!bus.flushed && cyc < 300) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    check("flushed", bus.flushed, 1);
    check("flush_writes_left", exp_m.size(), 0);
    bus.dmemREN = 1'b1;
    bus.dmemaddr = 32'h100;
    repeat (3) @(negedge CLK);
    #1;
    check("halted_dhit", bus.dhit, 0);
    check("halted_dren", bus.dREN, 0);
    check("flushed_sticky", bus.flushed, 1);
    bus.dmemREN = 1'b0;
    bus.halt = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("reset_flushed", bus.flushed, 0);
    @(negedge CLK);
    nRST = 1'b1;
    rd_m(32'h40);
    @(negedge CLK);
    bus.dmemREN = 1'b1;
    bus.dmemaddr = 32'h40;
    cyc = 0;
    #1;
    while (!(bus.dREN && bus.daddr == 32'h44) && cyc < 100) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    check("fetch1_seen", bus.dREN && bus.daddr == 32'h44, 1);
    nRST = 1'b0;
    #1;
    check("abort_dren", bus.dREN, 0);
    check("abort_dwen", bus.dWEN, 0);
    bus.dmemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    rd_m(32'h40); rd_m(32'h44);
    access(1, 0, 0, 32'h40, 0, 1, 32'hDEAD_BEEF, 1, 0);
    check("final_drain", exp_m.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dcache.md
Name: dcache

Overview:
- Data-cache responder on the datapath side of datapath_cache_if; it answers the pipeline's dmemREN/dmemWEN/datomic requests with dhit/dmemload.
- Direct-mapped, write-back, write-allocate cache with two-word blocks and an LL/SC link register.
- Backs onto the memory controller through a word-serial dREN/dWEN/dwait port.
- On halt it writes back all dirty blocks, then asserts flushed.

Parameters:
- SETS, 8, number of blocks; power of two. Index width IW = log2(SETS).
- TAG_W, 32-3-IW (=26), derived from SETS; not overridable.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- dmemREN  in  1  datapath load request
- dmemWEN  in  1  datapath store request; never asserted together with dmemREN
- datomic  in  1  qualifies request: REN = LL, WEN = SC
- dmemaddr  in  32  word address; bits [1:0] ignored
- dmemstore  in  32  store data
- halt  in  1  datapath halted; start flush
- dhit  out  1  request complete this cycle
- dmemload  out  32  load data; SC result (1/0) on SC
- flushed  out  1  flush complete; sticky until reset
- dREN  out  1  memory read request
- dWEN  out  1  memory write request
- daddr  out  32  memory word address
- dstore  out  32  memory write data
- dwait  in  1  memory busy; a transfer completes in the first cycle dwait=0 while requesting
- dload  in  32  memory read data

Behaviour:
- Reset: all valid/dirty bits 0, link_valid 0, state IDLE. All outputs 0.
- Address split: tag = [31:3+IW], index = [2+IW:3], blkoff = [2].
- IDLE hit (valid && tag match), combinational, same cycle:
  - Load: dhit=1, dmemload = word[blkoff].
  - Store: dhit=1; at the clock edge, write the word and set dirty.
- IDLE miss with a request:
  - If the victim is dirty: WB0 -> WB1 -> FETCH0 -> FETCH1 -> IDLE.
  - Otherwise: FETCH0 -> FETCH1 -> IDLE.
  - WBn: dWEN=1, daddr = {victim tag, index, n, 2'b00}, dstore = word n. Advance when dwait=0.
  - FETCHn: dREN=1, daddr = {req tag, index, n, 2'b00}. Capture dload when dwait=0.
  - After FETCH1: set valid, clear dirty, load new tag. The request then hits in IDLE on the next cycle.
- dhit is never asserted outside IDLE or for more than one cycle per completed access.
- LL (REN & datomic): performed as a load. On hit, link_addr <= dmemaddr[31:2] and link_valid <= 1.
- SC (WEN & datomic):
  - Success when link_valid && link_addr == dmemaddr[31:2]. Performed as a store (miss handling if needed); on its hit cycle dmemload = 1 and link_valid <= 0.
  - Failure: dhit=1 in IDLE the same cycle, dmemload=0, no write, no memory traffic.
- Any plain store hitting link_addr clears link_valid. Reset clears the link.
- Halt: checked in IDLE only; it takes priority over a new request.
  - FLUSH_CHK scans index 0..SETS-1 with a counter.
  - Dirty blocks go through FLUSH_WB0 -> FLUSH_WB1 and have their dirty bit cleared; clean blocks advance one index per cycle.
  - After the last index: HALTED. flushed=1; no further dhit or memory requests.
- A halt arriving mid-miss waits until the miss returns to IDLE.
- Reset mid-operation aborts any transfer immediately; dREN/dWEN drop asynchronously.
- dwait held high stalls any state indefinitely with outputs stable.

Optional Feature:
- Macro DCACHE_HITCNT_EN.
- Defined: 32-bit hit and miss counters.
  - A miss counts once on entry to a fill path.
  - A hit counts on an IDLE dhit not preceded by that request's fill; SC failures are not counted.
  - After the flush, state CNT_WR issues dWEN with daddr=32'h3100 and dstore = hits - misses, then goes to HALTED.
- Undefined: no counters and no CNT_WR state; the flush goes directly to HALTED.

Decomposition:
- Shared package dcache_pkg holds:
  - the dcache_state_t enum (IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FLUSH_WB0, FLUSH_WB1, CNT_WR, HALTED);
  - the dcache_frame_t struct (valid, dirty, tag, data[2]);
  - the HITCNT_ADDR = 32'h3100 constant.
- Word types come from cpu_types_pkg.
- One natural sub-module: dcache_frames, the storage array with synchronous write and combinational read of one index, instantiated by dcache.

Test Plan:
- Cold load 0x0000_0040, memory returns 0xAAAA_0001/0xAAAA_0002 after 2 dwait cycles each -> FETCH0/FETCH1 seen, then dhit with dmemload = 0xAAAA_0001. A load of 0x44 hits the same cycle with 0xAAAA_0002.
- Store 0xDEAD_BEEF to 0x40 (hit), then load 0x140 (same index, different tag) -> WB0/WB1 write 0xDEAD_BEEF@0x40 and 0xAAAA_0002@0x44 before FETCH0@0x140.
- LL 0x80, then SC 0x80 with data 5 -> dmemload=1 and a load of 0x80 returns 5. A second SC 0x80 -> dmemload=0, no memory traffic, data unchanged.
- LL 0x80, then plain store to 0x80, then SC 0x80 -> SC fails with dmemload=0. LL 0x80 followed by SC 0x84 also fails.
- Dirty blocks at indices 1 and 5, then assert halt -> exactly 4 memory writes in index order, then flushed=1 and stays 1. With DCACHE_HITCNT_EN defined, a fifth write to 0x3100 follows.
- Assert nRST low during FETCH1 -> dREN=0 immediately; after release, the previously filling block is invalid and the same load misses again.
